lsu_mem_master: RTL

- Load/store initiator that drives the data-side port of the simulation RAM responder on behalf of the execute stage.
- Accepts one request at a time over a valid/ready handshake.
- Checks width encoding, alignment and address range before touching memory, then issues a single-cycle memory strobe.
- Waits for the RAM's registered read data and returns a tagged response over a second valid/ready handshake.

---
 rtl/lsu_mem_master.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/lsu_mem_master.sv
// Load/store initiator for the data port of the simulation RAM.
// Takes one request at a time, checks it, strobes memory once and returns a tagged response.
module lsu_mem_master #(
  parameter int unsigned RAM_SIZE  = 16,
  parameter int unsigned TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [63:0]          req_addr_i,
  input  logic [63:0]          req_wdata_i,
  input  logic [2:0]           req_wid_i,
  input  logic [TAG_WIDTH-1:0] req_tag_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [63:0]          resp_rdata_o,
  output logic [TAG_WIDTH-1:0] resp_tag_o,
  output logic [1:0]           resp_err_o,
  output logic [63:0]          mem_addr_o,
  output logic                 mem_en_o,
  output logic                 mem_enwr_o,
  output logic [63:0]          mem_data_o,
  output logic [2:0]           mem_wid_o,
  input  logic [63:0]          mem_rdata_i,
  input  logic                 mem_unalign_i
);

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned WW = 3;
  localparam int unsigned EW = 2;

  localparam logic [EW-1:0] ERR_OK    = 2'b00;
  localparam logic [EW-1:0] ERR_MIS   = 2'b01;
  localparam logic [EW-1:0] ERR_FAULT = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 we_q, we_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [EW-1:0]        err_q, err_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic [AW-1:0]        maddr_q, maddr_d;
  logic [DW-1:0]        mdata_q, mdata_d;
  logic [WW-1:0]        mwid_q, mwid_d;

  logic                 wid_bad_c;
  logic                 misal_c;
  logic                 oor_c;
  logic [EW-1:0]        chk_err_c;

  // Request legality, first match wins: width encoding, alignment, range
  always_comb begin
    wid_bad_c = (req_wid_i == 3'b111) || (req_we_i && req_wid_i[2]);
    misal_c   = 1'b0;
    case (req_wid_i[1:0])
      2'b01:   misal_c = req_addr_i[0];
      2'b10:   misal_c = |req_addr_i[1:0];
      2'b11:   misal_c = |req_addr_i[2:0];
      default: misal_c = 1'b0;
    endcase
    oor_c = (req_addr_i >> RAM_SIZE) != 64'd0;
    if (wid_bad_c)    chk_err_c = ERR_FAULT;
    else if (misal_c) chk_err_c = ERR_MIS;
    else if (oor_c)   chk_err_c = ERR_FAULT;
    else              chk_err_c = ERR_OK;
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    tag_d   = tag_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    mwid_d  = mwid_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          tag_d   = req_tag_i;
          err_d   = chk_err_c;
          rdata_d = '0;
          if (chk_err_c != ERR_OK) begin
            state_d = S_RESP;
          end else begin
            // memory-side registers move only when a strobe will follow
            maddr_d = req_addr_i;
            mdata_d = req_wdata_i;
            mwid_d  = req_wid_i;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (mem_unalign_i) err_d = ERR_MIS;
        state_d = we_q ? S_RESP : S_CAPTURE;
      end
      S_CAPTURE: begin
        rdata_d = (err_q == ERR_OK) ? mem_rdata_i : '0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      tag_q   <= '0;
      err_q   <= ERR_OK;
      rdata_q <= '0;
      maddr_q <= '0;
      mdata_q <= '0;
      mwid_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      mwid_q  <= mwid_d;
    end
  end

  // Handshake and strobe outputs decode straight from the state flops
  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = (state_q == S_RESP);
  assign mem_en_o     = (state_q == S_ACCESS);
  assign mem_enwr_o   = !((state_q == S_ACCESS) && we_q);

  assign resp_rdata_o = rdata_q;
  assign resp_tag_o   = tag_q;
  assign resp_err_o   = err_q;
  assign mem_addr_o   = maddr_q;
  assign mem_data_o   = mdata_q;
  assign mem_wid_o    = mwid_q;

endmodule
